// File: rtl/crc_ser_pkg.sv
// Shared types and default sizing for the CRC frame serializer.
// The state encoding is common to the RTL and anything that decodes the state.
package crc_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_CRC = 2'd2,
        ST_DONE     = 2'd3
    } crc_ser_state_e;

    localparam int DEF_DATA_WD     = 8;
    localparam int DEF_CRC_WD      = 8;
    localparam int DEF_TIMEOUT_CYC = 32;

endpackage

// File: rtl/crc_frame_serializer.sv
// Serializes a parallel word LSB-first into a downstream CRC stage, then waits for its CRC bits.
// Optional WAIT_CRC watchdog enabled by defining CRC_SER_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | ready for a word; handshake loads the shift register
// ST_SHIFT    | SER_ACTIVE high, one message bit per cycle, DATA_WD cycles
// ST_WAIT_CRC | counting CRC_VALID high cycles until CRC_WD have been seen
// ST_DONE     | single-cycle FRAME_DONE pulse, then back to idle
module crc_frame_serializer
    import crc_ser_pkg::*;
#(
    parameter int DATA_WD     = DEF_DATA_WD,
    parameter int CRC_WD      = DEF_CRC_WD,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DATA_WD-1:0] IN_DATA,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic               SER_DATA,
    output logic               SER_ACTIVE,
    input  logic               CRC_VALID,
    output logic               BUSY,
    output logic               FRAME_DONE,
    output logic               ERR
);

    localparam int BCW = $clog2(DATA_WD + 1);
    localparam int CCW = $clog2(CRC_WD + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WD - 1);
    localparam logic [CCW-1:0] CRC_LAST = CCW'(CRC_WD - 1);

    crc_ser_state_e state, state_nxt;

    logic [DATA_WD-1:0] shreg;
    logic [BCW-1:0]     bit_cnt;
    logic [CCW-1:0]     crc_cnt;
    logic               shift_last;
    logic               crc_last;
    logic               timeout;

    // Both counters run down and terminate on zero.
    assign shift_last = (bit_cnt == '0);
    assign crc_last   = CRC_VALID && (crc_cnt == '0);

`ifdef CRC_SER_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WCW-1:0] WD_LAST = WCW'(TIMEOUT_CYC - 1);

    logic [WCW-1:0] wd_cnt;
    logic           err_q;

    // A frame completing on the same cycle the watchdog expires still counts as done.
    assign timeout = (wd_cnt == '0) && !crc_last;
    assign ERR     = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= (state == ST_WAIT_CRC) && timeout;
            if (state == ST_SHIFT && shift_last)
                wd_cnt <= WD_LAST;
            else if (state == ST_WAIT_CRC && wd_cnt != '0)
                wd_cnt <= wd_cnt - 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign ERR     = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        IN_READY   = 1'b0;
        SER_ACTIVE = 1'b0;
        BUSY       = 1'b1;
        FRAME_DONE = 1'b0;
        case (state)
            ST_IDLE: begin
                IN_READY = 1'b1;
                BUSY     = 1'b0;
                if (IN_VALID)
                    state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                SER_ACTIVE = 1'b1;
                if (shift_last)
                    state_nxt = ST_WAIT_CRC;
            end
            ST_WAIT_CRC: begin
                if (crc_last)
                    state_nxt = ST_DONE;
                else if (timeout)
                    state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                FRAME_DONE = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        SER_DATA = SER_ACTIVE & shreg[0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg   <= '0;
            bit_cnt <= '0;
            crc_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        shreg   <= IN_DATA;
                        bit_cnt <= BIT_LAST;
                    end
                end
                ST_SHIFT: begin
                    shreg <= {1'b0, shreg[DATA_WD-1:1]};
                    if (shift_last)
                        crc_cnt <= CRC_LAST;
                    else
                        bit_cnt <= bit_cnt - 1'b1;
                end
                ST_WAIT_CRC: begin
                    if (CRC_VALID && crc_cnt != '0)
                        crc_cnt <= crc_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer with hand-computed serial sequences.
// Timeout expectations follow the CRC_SER_TIMEOUT_EN define used for the build.
module tb_crc_frame_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ser_data;
    logic       ser_active;
    logic       crc_valid = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    int seq_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int seq_c3 [8] = '{1, 1, 0, 0, 0, 0, 1, 1};
    int seq_81 [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
    int seq_3c [8] = '{0, 0, 1, 1, 1, 1, 0, 0};

    always #5 clk = ~clk;

    crc_frame_serializer #(
        .DATA_WD    (8),
        .CRC_WD     (8),
        .TIMEOUT_CYC(32)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .SER_DATA  (ser_data),
        .SER_ACTIVE(ser_active),
        .CRC_VALID (crc_valid),
        .BUSY      (busy),
        .FRAME_DONE(frame_done),
        .ERR       (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {IN_READY, SER_ACTIVE, SER_DATA, BUSY, FRAME_DONE, ERR}
    task automatic check_reset_outs(input string tag);
        check_val(tag, {26'd0, in_ready, ser_active, ser_data, busy, frame_done, err}, 32'b100000);
    endtask

    task automatic send_word(input string tag, input logic [7:0] d, input bit hold);
        in_data  = d;
        in_valid = 1'b1;
        check_val({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        if (!hold)
            in_valid = 1'b0;
    endtask

    // {SER_ACTIVE, SER_DATA, IN_READY} each shift cycle, then WAIT_CRC entry
    task automatic shift_check(input string tag, input int seq [8]);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("%s_b%0d", tag, i),
                      {29'd0, ser_active, ser_data, in_ready},
                      {29'd0, 1'b1, seq[i][0], 1'b0});
            tick();
        end
        check_val({tag, "_wait"}, {29'd0, ser_active, ser_data, busy}, 32'b001);
    endtask

    task automatic crc_burst(input string tag, input int n);
        crc_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_hi%0d", tag, i), {30'd0, frame_done, busy}, 32'b01);
            tick();
        end
        crc_valid = 1'b0;
    endtask

    task automatic crc_gap(input string tag, input int n);
        crc_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_lo%0d", tag, i), {30'd0, frame_done, busy}, 32'b01);
            tick();
        end
    endtask

    // {FRAME_DONE, BUSY, IN_READY} in DONE, then in the following IDLE cycle
    task automatic done_check(input string tag);
        check_val({tag, "_done"}, {29'd0, frame_done, busy, in_ready}, 32'b110);
        tick();
        check_val({tag, "_idle"}, {29'd0, frame_done, busy, in_ready}, 32'b001);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int bad_cnt;

        #1;
        check_reset_outs("por");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset_outs("post_rst");

        // A5 with CRC_VALID already high during SHIFT: must be ignored there
        send_word("a5", 8'hA5, 1'b0);
        crc_valid = 1'b1;
        shift_check("a5", seq_a5);
        crc_burst("a5", 8);
        done_check("a5");

        // CRC_VALID 4 high, 3 low, 4 high
        send_word("c3", 8'hC3, 1'b0);
        shift_check("c3", seq_c3);
        crc_burst("gap_a", 4);
        crc_gap("gap", 3);
        crc_burst("gap_b", 4);
        done_check("gap");

        // 3C held on IN_VALID while the 81 frame is busy
        send_word("f81", 8'h81, 1'b1);
        in_data = 8'h3C;
        shift_check("f81", seq_81);
        crc_burst("f81", 8);
        done_check("f81");
        tick();
        in_valid = 1'b0;
        shift_check("f3c", seq_3c);
        crc_burst("f3c", 8);
        done_check("f3c");

        // Reset asserted during the 4th SHIFT cycle
        send_word("rst", 8'hA5, 1'b0);
        tick();
        tick();
        tick();
        check_val("rst_shift4", {30'd0, ser_active, ser_data}, 32'b10);
        rst = 1'b1;
        crc_valid = 1'b1;
        #1;
        check_reset_outs("rst_async");
        tick();
        tick();
        rst = 1'b0;
        bad_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (frame_done || err || busy)
                bad_cnt++;
        end
        crc_valid = 1'b0;
        check_val("rst_no_pulse", bad_cnt, 32'd0);

        // No CRC_VALID at all in WAIT_CRC
        send_word("to", 8'hC3, 1'b0);
        shift_check("to", seq_c3);
`ifdef CRC_SER_TIMEOUT_EN
        for (int i = 0; i < 32; i++) begin
            check_val($sformatf("to_wait%0d", i), {30'd0, err, busy}, 32'b01);
            tick();
        end
        check_val("to_err", {29'd0, err, busy, in_ready}, 32'b101);
        check_val("to_nodone", {31'd0, frame_done}, 32'd0);
        tick();
        check_val("to_err_end", {29'd0, err, busy, in_ready}, 32'b001);
`else
        for (int i = 0; i < 40; i++) begin
            check_val($sformatf("to_wait%0d", i), {30'd0, err, busy}, 32'b01);
            tick();
        end
        crc_burst("to_late", 8);
        done_check("to_late");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_frame_serializer.md
CRC_FRAME_SERIALIZER -- requirements
Module: crc_frame_serializer

Interface
REQ-001 SHALL have parameter DATA_WD, default 8, message word width in bits (legal range 8..32).
REQ-002 SHALL have parameter CRC_WD, default 8, number of serial CRC bits the downstream CRC stage emits per frame.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 32, WAIT_CRC watchdog limit in clock cycles.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port IN_DATA  input  DATA_WD  parallel message word.
REQ-007 SHALL have port IN_VALID  input  1  IN_DATA holds a valid word.
REQ-008 SHALL have port IN_READY  output  1  block can accept a word this cycle.
REQ-009 SHALL have port SER_DATA  output  1  serial bit to the CRC stage's DATA input.
REQ-010 SHALL have port SER_ACTIVE  output  1  drives the CRC stage's ACTIVE input.
REQ-011 SHALL have port CRC_VALID  input  1  the CRC stage's Valid output.
REQ-012 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-013 SHALL have port FRAME_DONE  output  1  one-cycle pulse when a frame's CRC has fully emerged.
REQ-014 SHALL have port ERR  output  1  one-cycle watchdog pulse.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, WAIT_CRC, DONE.
REQ-016 SHALL drive IN_READY=1 only in IDLE; a handshake occurs on a rising edge with IN_VALID=1 and IN_READY=1.
REQ-017 SHALL load IN_DATA into a DATA_WD shift register on the handshake and enter SHIFT on the next cycle.
REQ-018 SHALL, in SHIFT, drive SER_ACTIVE=1 and SER_DATA=shreg[0], shifting right once per cycle, LSB first.
REQ-019 SHALL remain in SHIFT for exactly DATA_WD cycles, counted by a bit counter, then enter WAIT_CRC with SER_ACTIVE=0.
REQ-020 SHALL drive SER_DATA=0 whenever SER_ACTIVE=0.
REQ-021 SHALL ignore CRC_VALID in IDLE and SHIFT.
REQ-022 SHALL, in WAIT_CRC, count only cycles with CRC_VALID=1; a low gap holds the count, it does not clear it.
REQ-023 SHALL enter DONE on the cycle after the CRC_WD-th CRC_VALID=1 cycle.
REQ-024 SHALL assert FRAME_DONE=1 for the single DONE cycle, then return to IDLE.
REQ-025 SHALL, while IN_VALID is held with IN_READY=0, neither consume nor corrupt the pending word.
REQ-026 SHALL give a back-to-back frame period of 1 (accept) + DATA_WD + CRC_VALID latency + CRC_WD + 1 (DONE) cycles.

Reset
REQ-027 SHALL on RST=1 immediately set state=IDLE, shift register=0, all counters=0, IN_READY=1, SER_ACTIVE=0, SER_DATA=0, BUSY=0, FRAME_DONE=0, ERR=0.
REQ-028 SHALL abandon an in-flight frame on reset mid-operation, with no FRAME_DONE or ERR pulse for it.

Configuration
REQ-029 SHALL, with macro CRC_SER_TIMEOUT_EN defined, count every cycle spent in WAIT_CRC.
REQ-030 SHALL, with CRC_SER_TIMEOUT_EN defined, pulse ERR=1 for one cycle and return to IDLE if the count reaches TIMEOUT_CYC before REQ-023 is met; FRAME_DONE is not asserted.
REQ-031 SHALL, without CRC_SER_TIMEOUT_EN, tie ERR to 0, omit the watchdog counter, and wait in WAIT_CRC indefinitely.

Structure
REQ-032 SHALL place the state enum typedef and the default DATA_WD/CRC_WD/TIMEOUT_CYC constants in shared package crc_ser_pkg.
REQ-033 SHALL be a single module with no sub-module; counters and the FSM are inline.

Verification
REQ-034 SHALL cover: accept IN_DATA=8'hA5 -> SER_ACTIVE high 8 cycles, SER_DATA sequence 1,0,1,0,0,1,0,1.
REQ-035 SHALL cover: CRC_VALID high 8 consecutive cycles in WAIT_CRC -> FRAME_DONE single pulse on the next cycle, IN_READY=1 the cycle after.
REQ-036 SHALL cover: CRC_VALID pattern 4 high, 3 low, 4 high -> FRAME_DONE one cycle after the 8th high cycle.
REQ-037 SHALL cover: IN_VALID held with 8'h3C during BUSY -> word accepted only on return to IDLE, serialized intact.
REQ-038 SHALL cover: RST pulse at the 4th SHIFT cycle -> all outputs at reset values immediately, no FRAME_DONE.
REQ-039 SHALL cover: with CRC_SER_TIMEOUT_EN, CRC_VALID held 0 -> ERR pulse after 32 WAIT_CRC cycles and return to IDLE; without the macro, ERR stays 0 and BUSY stays 1.
